// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 timing constants and the shared coordinate type
// for every block that consumes DrawX/DrawY.
package vga_timing_pkg;

   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

   typedef logic [9:0] coord_t;

endpackage

// File: rtl/vga_delay_line.sv
// Width/depth-parameterised shift register with a synchronous reset value;
// DEPTH=0 degenerates to a wire.
module vga_delay_line #(
   parameter int               WIDTH     = 3,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             vga_clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign dout = din;
      end else begin : g_pipe
         logic [WIDTH-1:0] stage [DEPTH];

         // Reset flushes every stage so no partial pulse survives a mid-frame reset.
         always_ff @(posedge vga_clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= RESET_VAL;
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter and delayed sync/blank generator driving the pixel interface.
// Optional 16-bit frame counter port is enabled with VGA_FRAME_CNT_EN.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
   parameter int H_FP      = vga_timing_pkg::H_FP,
   parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
   parameter int H_BP      = vga_timing_pkg::H_BP,
   parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
   parameter int V_FP      = vga_timing_pkg::V_FP,
   parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
   parameter int V_BP      = vga_timing_pkg::V_BP,
   parameter int PIPE_DLY  = 2
) (
   input  logic       vga_clk,
   input  logic       reset,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hs,
   output logic       vs,
   output logic       sof
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int LINE_CLKS   = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;

   generate
      if (LINE_CLKS > 1024 || FRAME_LINES > 1024 || PIPE_DLY > 4 || PIPE_DLY < 0) begin : g_bad_cfg
         $error("vga_timing_gen: totals must fit 10-bit counters and PIPE_DLY must be 0..4");
      end
   endgenerate

   localparam coord_t H_LAST    = coord_t'(LINE_CLKS - 1);
   localparam coord_t V_LAST    = coord_t'(FRAME_LINES - 1);
   localparam coord_t H_VIS_END = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_END = coord_t'(V_VISIBLE);
   localparam coord_t HS_START  = coord_t'(H_VISIBLE + H_FP);
   localparam coord_t HS_END    = coord_t'(H_VISIBLE + H_FP + H_SYNC);
   localparam coord_t VS_START  = coord_t'(V_VISIBLE + V_FP);
   localparam coord_t VS_END    = coord_t'(V_VISIBLE + V_FP + V_SYNC);

   coord_t hc;
   coord_t vc;
   logic   line_end;
   logic   frame_end;

   assign line_end  = (hc == H_LAST);
   assign frame_end = line_end && (vc == V_LAST);

   // Horizontal and vertical counters wrap together at the last pixel of the frame.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         hc <= '0;
         vc <= '0;
      end else if (line_end) begin
         hc <= '0;
         vc <= (vc == V_LAST) ? coord_t'(0) : vc + coord_t'(1);
      end else begin
         hc <= hc + coord_t'(1);
      end
   end

   assign DrawX = hc;
   assign DrawY = vc;
   assign sof   = !reset && (hc == '0) && (vc == '0);

   logic blank_r;
   logic hs_r;
   logic vs_r;

   always_comb begin
      blank_r = (hc < H_VIS_END) && (vc < V_VIS_END);
      hs_r    = !((hc >= HS_START) && (hc < HS_END));
      vs_r    = !((vc >= VS_START) && (vc < VS_END));
   end

   // Idle value {blank=0, hs=1, vs=1} is what the pipe shows during and right after reset.
   logic [2:0] timing_dly;

   vga_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DLY),
      .RESET_VAL (3'b011)
   ) u_delay (
      .vga_clk (vga_clk),
      .reset   (reset),
      .din     ({blank_r, hs_r, vs_r}),
      .dout    (timing_dly)
   );

   assign blank = timing_dly[2];
   assign hs    = timing_dly[1];
   assign vs    = timing_dly[0];

`ifdef VGA_FRAME_CNT_EN
   // Counts completed frames for sprite animation and blink timing; wraps naturally at 16 bits.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (frame_end) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: a cycle-index reference model predicts
// every output each clock while random and directed resets are applied.
module tb_vga_timing_gen;

   localparam int HV = 640;
   localparam int HF = 16;
   localparam int HS = 96;
   localparam int HB = 48;
   localparam int VV = 12;
   localparam int VF = 2;
   localparam int VS = 2;
   localparam int VB = 4;
   localparam int DLY = 2;

   localparam longint H_TOT = HV + HF + HS + HB;
   localparam longint V_TOT = VV + VF + VS + VB;
   localparam longint FRAME = H_TOT * V_TOT;

   logic       vgaClk;
   logic       reset;
   logic [9:0] drawX;
   logic [9:0] drawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       sof;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frameCnt;
`endif

   int     errors = 0;
   int     checks = 0;
   longint t = 0;
   bit     rstCur = 1'b1;

   vga_timing_gen #(
      .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .PIPE_DLY  (DLY)
   ) dut (
      .vga_clk   (vgaClk),
      .reset     (reset),
      .DrawX     (drawX),
      .DrawY     (drawY),
      .blank     (blank),
      .hs        (hs),
      .vs        (vs),
      .sof       (sof)
`ifdef VGA_FRAME_CNT_EN
      ,
      .frame_cnt (frameCnt)
`endif
   );

   initial vgaClk = 1'b0;
   always #5 vgaClk = ~vgaClk;

   function automatic longint posX(input longint p);
      return p % H_TOT;
   endfunction

   function automatic longint posY(input longint p);
      return (p / H_TOT) % V_TOT;
   endfunction

   // Timing of the raster position p cycles into a frame, derived from the porch rules.
   function automatic logic [2:0] rawTiming(input longint p);
      longint x;
      longint y;
      logic   b;
      logic   h;
      logic   v;
      x = posX(p);
      y = posY(p);
      b = (x < HV) && (y < VV);
      h = !((x >= HV + HF) && (x < HV + HF + HS));
      v = !((y >= VV + VF) && (y < VV + VF + VS));
      return {b, h, v};
   endfunction

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic checkOutput();
      logic [2:0] expTim;
      expTim = (t < DLY) ? 3'b011 : rawTiming(t - DLY);
      checkOne("DrawX", {22'd0, drawX}, 32'(posX(t)));
      checkOne("DrawY", {22'd0, drawY}, 32'(posY(t)));
      checkOne("blank", {31'd0, blank}, {31'd0, expTim[2]});
      checkOne("hs",    {31'd0, hs},    {31'd0, expTim[1]});
      checkOne("vs",    {31'd0, vs},    {31'd0, expTim[0]});
      checkOne("sof",   {31'd0, sof},   {31'd0, (!rstCur && (t % FRAME == 0))});
`ifdef VGA_FRAME_CNT_EN
      checkOne("frame_cnt", {16'd0, frameCnt}, {16'd0, 16'((t / FRAME) & 64'hFFFF)});
`endif
   endtask

   // One clock: the edge consumes the reset level chosen last cycle, then the next level is driven.
   task automatic applyStimulus(input bit nextRst);
      @(posedge vgaClk);
      #1;
      if (rstCur) t = 0;
      else        t++;
      reset  = nextRst;
      rstCur = nextRst;
      #1;
      checkOutput();
   endtask

   initial begin
      int  guard;
      reset  = 1'b1;
      rstCur = 1'b1;
      $display("[TB] reset held for 5 clocks");
      for (int i = 0; i < 4; i++) applyStimulus(1'b1);
      applyStimulus(1'b0);

      $display("[TB] free run over three frames");
      for (int i = 0; i < 3 * FRAME + 200; i++) applyStimulus(1'b0);

      $display("[TB] directed reset at DrawX=700 DrawY=5");
      guard = 0;
      while (!(posX(t) == 700 && posY(t) == 5) && guard < 2 * FRAME) begin
         applyStimulus(1'b0);
         guard++;
      end
      checks++;
      assert (guard < 2 * FRAME) else begin
         errors++;
         $error("[TB] FAIL reach_700_5 observed=timeout expected=position reached");
      end
      reset  = 1'b1;
      rstCur = 1'b1;
      #1;
      checkOutput();
      for (int i = 0; i < 2000; i++) applyStimulus(1'b0);

      $display("[TB] random reset pulses");
      for (int i = 0; i < 6000; i++) begin
         applyStimulus($urandom_range(0, 799) == 0);
      end
      for (int i = 0; i < 50; i++) applyStimulus(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
